// File: rtl/imem_pkg.sv
// Shared instruction-memory geometry and the loader state encoding.
package imem_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  typedef logic [1:0] loader_state_t;
  localparam loader_state_t ST_IDLE   = 2'd0;
  localparam loader_state_t ST_LOAD   = 2'd1;
  localparam loader_state_t ST_FINISH = 2'd2;
  localparam loader_state_t ST_DONE   = 2'd3;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes MSB-first into an instruction word; pulses word_ready with the
// completed word on the cycle its last byte arrives (combinational, zero latency).
module byte_packer
  import imem_pkg::*;
#(
  parameter int INSTR_W = imem_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_vld,
  input  logic [7:0]         byte_dat,
  output logic               word_ready,
  output logic [INSTR_W-1:0] word_dat
);
  localparam int BPW   = INSTR_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [INSTR_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last;

  assign last       = (cnt_q == CNT_W'(BPW - 1));
  assign shift_d    = {shift_q[INSTR_W-9:0], byte_dat};
  assign cnt_d      = last ? '0 : cnt_q + CNT_W'(1);
  assign word_ready = byte_vld && last && !clear;
  assign word_dat   = shift_d;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_vld) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as packed words at consecutive addresses;
// write strobe follows the word's last byte by one cycle, abort suppresses any pending write.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W  = imem_pkg::ADDR_W,
  parameter int INSTR_W = imem_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  word_count,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done
);
  loader_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               pk_clear;
  logic               word_ready;
  logic [INSTR_W-1:0] word_dat;

  byte_packer #(.INSTR_W(INSTR_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .byte_vld  (rx_valid && rx_ready),
    .byte_dat  (rx_data),
    .word_ready(word_ready),
    .word_dat  (word_dat)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pk_clear  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d  = ST_LOAD;
          base_d   = base_addr;
          count_d  = word_count;
          idx_d    = '0;
          pk_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d  = ST_IDLE;
          pk_clear = 1'b1;
        end else if (word_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + idx_q;
          wr_data_d = word_dat;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == count_q) state_d = ST_FINISH;
        end
      end
      default: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // An abort landing on the write cycle (including FINISH) must still kill that write.
  assign wr_en    = wr_en_q && !abort;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rx_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_FINISH);
  assign done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, streaming, wrap, stalls, abort and control edge cases.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, abort, rx_valid;
  logic [7:0]  base_addr, word_count, rx_data;
  logic        rx_ready, wr_en, busy, done;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_start(input logic [7:0] b, input logic [7:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Nine bytes 01..09 -> words 010203/040506/070809 at base, base+1, base+2 (mod 256).
  task automatic stream3(input logic [7:0] base, input bit gaps);
    logic [7:0]  a;
    logic [23:0] w;
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        repeat (g) begin
          rx_valid = 1'b0;
          tick();
          chk("stall_wr_en", 32'(wr_en), 32'd0);
        end
      end
      rx_valid = 1'b1; rx_data = 8'(i + 1);
      tick();
      if (i % 3 == 2) begin
        a = base + 8'(i / 3);
        w = {8'(i - 1), 8'(i), 8'(i + 1)};
        chk("stream_wr_en", 32'(wr_en), 32'd1);
        chk("stream_wr_addr", 32'(wr_addr), 32'(a));
        chk("stream_wr_data", 32'(wr_data), 32'(w));
      end else begin
        chk("stream_no_wr", 32'(wr_en), 32'd0);
      end
    end
    rx_valid = 1'b0;
    chk("stream_rx_ready_off", 32'(rx_ready), 32'd0);
    tick();
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_busy_off", 32'(busy), 32'd0);
    chk("stream_wr_en_off", 32'(wr_en), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
    base_addr = 8'h00; word_count = 8'h00; rx_data = 8'h00;
    tick(); tick();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Single word
    load_start(8'h00, 8'h00);
    send(8'h12); send(8'h34);
    chk("single_no_early_wr", 32'(wr_en), 32'd0);
    send(8'h56);
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_wr_addr", 32'(wr_addr), 32'h00);
    chk("single_wr_data", 32'(wr_data), 32'h123456);
    chk("single_finish_rdy", 32'(rx_ready), 32'd0);
    chk("single_finish_busy", 32'(busy), 32'd1);
    tick();
    chk("single_done", 32'(done), 32'd1);
    chk("single_wr_en_off", 32'(wr_en), 32'd0);
    chk("single_hold_data", 32'(wr_data), 32'h123456);

    // Streaming, wrap, and stalled streaming (each starts from DONE)
    load_start(8'h10, 8'd2);
    stream3(8'h10, 1'b0);
    load_start(8'hFE, 8'd2);
    stream3(8'hFE, 1'b0);
    load_start(8'h10, 8'd2);
    stream3(8'h10, 1'b1);

    // Abort after two bytes, then a clean reload
    load_start(8'h40, 8'h00);
    send(8'hAA); send(8'hBB);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    chk("abort_wr_en_later", 32'(wr_en), 32'd0);
    load_start(8'h40, 8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    chk("reload_wr_en", 32'(wr_en), 32'd1);
    chk("reload_wr_addr", 32'(wr_addr), 32'h40);
    chk("reload_wr_data", 32'(wr_data), 32'h112233);
    tick();

    // start during LOAD is ignored
    load_start(8'h20, 8'h00);
    send(8'hA1);
    start = 1'b1; base_addr = 8'h80; word_count = 8'h05;
    send(8'hA2);
    start = 1'b0;
    send(8'hA3);
    chk("midstart_wr_en", 32'(wr_en), 32'd1);
    chk("midstart_wr_addr", 32'(wr_addr), 32'h20);
    chk("midstart_wr_data", 32'(wr_data), 32'hA1A2A3);
    tick();
    chk("midstart_done", 32'(done), 32'd1);

    // abort in DONE clears done
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_abort_done", 32'(done), 32'd0);
    chk("done_abort_busy", 32'(busy), 32'd0);

    // abort coinciding with the word-completing byte
    load_start(8'h30, 8'h00);
    send(8'hC1); send(8'hC2);
    abort = 1'b1; rx_valid = 1'b1; rx_data = 8'hC3;
    tick();
    abort = 1'b0; rx_valid = 1'b0;
    chk("abort3_wr_en", 32'(wr_en), 32'd0);
    chk("abort3_busy", 32'(busy), 32'd0);
    tick();
    chk("abort3_wr_en_later", 32'(wr_en), 32'd0);
    chk("abort3_done", 32'(done), 32'd0);

    // abort during FINISH suppresses the final write
    load_start(8'h31, 8'h00);
    send(8'hD1); send(8'hD2); send(8'hD3);
    chk("fin_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    #1;
    chk("fin_abort_wr_en", 32'(wr_en), 32'd0);
    tick();
    abort = 1'b0;
    chk("fin_abort_busy", 32'(busy), 32'd0);
    chk("fin_abort_done", 32'(done), 32'd0);

    // reset mid-load
    load_start(8'h50, 8'h01);
    send(8'hE1); send(8'hE2); send(8'hE3);
    chk("rstmid_wr_addr_pre", 32'(wr_addr), 32'h50);
    rx_valid = 1'b1; rx_data = 8'hE4; reset = 1'b1;
    tick();
    reset = 1'b0; rx_valid = 1'b0;
    chk("rstmid_rx_ready", 32'(rx_ready), 32'd0);
    chk("rstmid_wr_en", 32'(wr_en), 32'd0);
    chk("rstmid_wr_addr", 32'(wr_addr), 32'd0);
    chk("rstmid_wr_data", 32'(wr_data), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
